wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Arbiter for the single register-file write port fed by writeback. It shares the port between the in-order pipeline writeback (normal priority) and a long-latency unit (divider/external load return) whose results arrive out of band through a valid/ready handshake. Long-latency results are buffered in a small FIFO. A starvation counter can stall the pipeline for one cycle to drain the FIFO. The block sits between the writeback stage outputs and the register file.

## Interface
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may wait before stall_o is raised
- clk_in  input  1  clock; all state on rising edge
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  global enable; low = freeze state, no writes
- pipe_rd_addr_i  input  5  pipeline writeback destination
- pipe_rd_write_i  input  1  pipeline write request
- pipe_rd_data_i  input  32  pipeline writeback data
- lu_valid_i  input  1  long-latency result valid
- lu_ready_o  output  1  FIFO can accept a result
- lu_rd_addr_i  input  5  long-latency result destination
- lu_rd_data_i  input  32  long-latency result data
- rd_write_o  output  1  register-file write enable
- rd_addr_o  output  5  register-file write address
- rd_data_o  output  32  register-file write data
- stall_o  output  1  pipeline must hold writeback; the current pipeline write is NOT performed
- lu_pending_o  output  1  FIFO non-empty

## Operation
- Effective pipeline request: pipe_rd_write_i && pipe_rd_addr_i != 0. A request to x0 is treated as idle.
- Effective LU request: lu_valid_i && lu_ready_o. If lu_rd_addr_i == 0, the handshake completes and the result is discarded.
- Port selection, combinational, in priority order:
  1. stall_o = 1: write the FIFO head.
  2. Pipeline request: write the pipeline data.
  3. FIFO non-empty: write the head and pop it.
  4. FIFO empty and LU request: bypass, write LU data directly; nothing is enqueued.
  5. Otherwise rd_write_o = 0. rd_addr_o/rd_data_o = 0.
- Enqueue: an LU request that is not bypassed is pushed at the tail. Push and pop in the same cycle are allowed.
- lu_ready_o = rdy_in && count < FIFO_DEPTH, from registered count only. When full, it stays low even if a pop happens this cycle.
- Ordering: a pipeline write is younger than any buffered LU result. When the pipeline write to rd is performed, every valid FIFO entry with the same rd is invalidated. Invalidated entries still occupy slots and pop without asserting rd_write_o. They do count as a head pop that cycle.
- Starvation counter (0..STARVE_LIMIT): increments each cycle the FIFO is non-empty and the head is not popped. It clears on any pop or when the FIFO is empty, and saturates.
- stall_o = rdy_in && counter == STARVE_LIMIT && effective pipeline request && FIFO non-empty.
  - If the head is invalidated, the pop happens, stall_o is still high, and no write occurs.
  - The pipeline re-presents its write the next cycle.
- rdy_in low: all outputs 0, no push/pop, counter held.

## Timing
- Reset (asynchronous): FIFO empty, pointers 0, counter 0. rd_write_o = 0, stall_o = 0, lu_pending_o = 0, lu_ready_o = 0 while rst_in is high. lu_ready_o = 1 on the first cycle after release (with rdy_in = 1).
- Write-port outputs and stall_o are combinational from inputs and state, with zero latency.
- FIFO, counter and invalidation take effect at the next clock edge. lu_pending_o is registered-state based.
- Minimum buffered latency: LU result enqueued in cycle N, written in cycle N+1 if the port is free.
- Worst-case buffered latency per entry: STARVE_LIMIT+1 cycles at the head.
- Pointer wrap: modulo FIFO_DEPTH with a separate count. Full means count == FIFO_DEPTH.
- Reset mid-operation discards all buffered entries; no write is issued.

## Test plan
- Pipeline only: write x5 = 0x11, then x0 = 0x22. Required: one write x5/0x11; the x0 cycle has rd_write_o = 0.
- Bypass: FIFO empty, pipeline idle, LU x7 = 0xABCD. Required: same-cycle write x7/0xABCD, lu_pending_o stays 0.
- Buffer then drain: pipeline writes every cycle while LU sends x3 = 1 then x4 = 2. Required:
  - lu_ready_o drops after 2 pushes.
  - On the cycle the counter reaches 4, stall_o = 1 and x3 = 1 is written.
  - The pipeline write is re-presented and performed next.
  - x4 = 2 is written after another 4-cycle wait.
- Invalidation: x9 = 0x55 buffered, then pipeline writes x9 = 0x66. Required: the FIFO entry is killed and the final x9 value is 0x66 (0x55 never written).
- rdy_in low for 3 cycles with the FIFO holding one entry. Required: no writes, lu_ready_o = 0, counter frozen; state resumes intact afterwards.
- Assert rst_in asynchronously with 2 entries buffered. Required: immediate rd_write_o = 0 and lu_pending_o = 0; the entries are never written.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback versus buffered long-latency results,
// with a starvation counter that stalls the pipeline for one cycle to drain the buffer.
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [4:0]  pipe_rd_addr_i,
  input  logic        pipe_rd_write_i,
  input  logic [31:0] pipe_rd_data_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_rd_addr_i,
  input  logic [31:0] lu_rd_data_i,
  output logic        rd_write_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        stall_o,
  output logic        lu_pending_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Buffer storage; fifo_vld marks entries not yet killed by a younger pipeline write.
  logic [4:0]            fifo_addr [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [SW-1:0]         starve_q;

  logic        active;
  logic        fifo_nonempty;
  logic        head_vld;
  logic        pipe_req;
  logic        lu_req;
  logic        stall;
  logic        pop;
  logic        push;
  logic        bypass;
  logic        pipe_done;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign active        = rdy_in && !rst_in;
  assign fifo_nonempty = (count_q != '0);
  assign head_vld      = fifo_vld[rd_ptr_q];
  assign pipe_req      = pipe_rd_write_i && (pipe_rd_addr_i != 5'd0);

  // Handshake: a long-latency result transfers in any cycle where lu_valid_i and
  // lu_ready_o are both high; lu_ready_o depends only on registered occupancy.
  assign lu_ready_o = active && (count_q < COUNT_FULL);
  assign lu_req     = lu_valid_i && lu_ready_o;

  assign stall = active && (starve_q == STARVE_MAX) && pipe_req && fifo_nonempty;

  always_comb begin
    pop       = 1'b0;
    bypass    = 1'b0;
    pipe_done = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'd0;
    if (active) begin
      if (stall) begin
        pop = 1'b1;
        if (head_vld) begin
          wr_en   = 1'b1;
          wr_addr = fifo_addr[rd_ptr_q];
          wr_data = fifo_data[rd_ptr_q];
        end
      end else if (pipe_req) begin
        pipe_done = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = pipe_rd_addr_i;
        wr_data   = pipe_rd_data_i;
      end else if (fifo_nonempty) begin
        pop = 1'b1;
        if (head_vld) begin
          wr_en   = 1'b1;
          wr_addr = fifo_addr[rd_ptr_q];
          wr_data = fifo_data[rd_ptr_q];
        end
      end else if (lu_req) begin
        // Port is free and nothing is queued ahead: write straight through.
        bypass = 1'b1;
        if (lu_rd_addr_i != 5'd0) begin
          wr_en   = 1'b1;
          wr_addr = lu_rd_addr_i;
          wr_data = lu_rd_data_i;
        end
      end
    end
  end

  // Results destined for x0 complete the handshake but are dropped.
  assign push = lu_req && !bypass && (lu_rd_addr_i != 5'd0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      fifo_vld <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= 5'd0;
        fifo_data[i] <= 32'd0;
      end
    end else if (rdy_in) begin
      // A performed pipeline write is younger than every buffered result to the same rd.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (pipe_done && fifo_vld[i] && (fifo_addr[i] == pipe_rd_addr_i)) begin
          fifo_vld[i] <= 1'b0;
        end
      end
      if (pop) begin
        fifo_vld[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        fifo_vld[wr_ptr_q]  <= 1'b1;
        fifo_addr[wr_ptr_q] <= lu_rd_addr_i;
        fifo_data[wr_ptr_q] <= lu_rd_data_i;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (!fifo_nonempty || pop) begin
        starve_q <= '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end

  assign rd_write_o   = wr_en;
  assign rd_addr_o    = wr_addr;
  assign rd_data_o    = wr_data;
  assign stall_o      = stall;
  assign lu_pending_o = active && fifo_nonempty;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: pipeline-only, bypass, buffer/drain with starvation stall,
// invalidation, rdy_in freeze and asynchronous reset with buffered entries.
module tb_wb_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [4:0]  pipe_rd_addr_i;
  logic        pipe_rd_write_i;
  logic [31:0] pipe_rd_data_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_rd_addr_i;
  logic [31:0] lu_rd_data_i;
  logic        rd_write_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        stall_o;
  logic        lu_pending_o;

  int pass_cnt;
  int total_cnt;

  wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .pipe_rd_addr_i  (pipe_rd_addr_i),
    .pipe_rd_write_i (pipe_rd_write_i),
    .pipe_rd_data_i  (pipe_rd_data_i),
    .lu_valid_i      (lu_valid_i),
    .lu_ready_o      (lu_ready_o),
    .lu_rd_addr_i    (lu_rd_addr_i),
    .lu_rd_data_i    (lu_rd_data_i),
    .rd_write_o      (rd_write_o),
    .rd_addr_o       (rd_addr_o),
    .rd_data_o       (rd_data_o),
    .stall_o         (stall_o),
    .lu_pending_o    (lu_pending_o)
  );

  // Clock and reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    pipe_rd_write_i = 1'b0;
    pipe_rd_addr_i  = 5'd0;
    pipe_rd_data_i  = 32'd0;
    lu_valid_i      = 1'b0;
    lu_rd_addr_i    = 5'd0;
    lu_rd_data_i    = 32'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_rd_write_i = 1'b1;
    pipe_rd_addr_i  = a;
    pipe_rd_data_i  = d;
  endtask

  task automatic drive_lu(input logic [4:0] a, input logic [31:0] d);
    lu_valid_i   = 1'b1;
    lu_rd_addr_i = a;
    lu_rd_data_i = d;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    drive_idle();
    drive_pipe(5'd5, 32'h99);
    drive_lu(5'd6, 32'h98);
    #2;
    total_cnt++;
    if ({rd_write_o, stall_o, lu_pending_o, lu_ready_o} !== 4'b0000) begin
      $display("FAIL reset_outputs: got wr/stall/pend/rdy=%b required 0000",
               {rd_write_o, stall_o, lu_pending_o, lu_ready_o});
    end else pass_cnt++;
    step();
    step();
    drive_idle();
    rst_in = 1'b0;
    #2;
    total_cnt++;
    if ({lu_ready_o, lu_pending_o, rd_write_o} !== 3'b100) begin
      $display("FAIL reset_release: got rdy/pend/wr=%b required 100",
               {lu_ready_o, lu_pending_o, rd_write_o});
    end else pass_cnt++;
    step();
  endtask

  task automatic test_pipe_only();
    drive_pipe(5'd5, 32'h11);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o, stall_o} !== {1'b1, 5'd5, 32'h11, 1'b0}) begin
      $display("FAIL pipe_x5: got wr=%b a=%0d d=%h st=%b required wr=1 a=5 d=11 st=0",
               rd_write_o, rd_addr_o, rd_data_o, stall_o);
    end else pass_cnt++;
    step();
    drive_pipe(5'd0, 32'h22);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o} !== {1'b0, 5'd0, 32'h0}) begin
      $display("FAIL pipe_x0: got wr=%b a=%0d d=%h required wr=0 a=0 d=0",
               rd_write_o, rd_addr_o, rd_data_o);
    end else pass_cnt++;
    step();
    drive_idle();
  endtask

  task automatic test_bypass();
    drive_lu(5'd7, 32'hABCD);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o, lu_ready_o, lu_pending_o} !==
        {1'b1, 5'd7, 32'hABCD, 1'b1, 1'b0}) begin
      $display("FAIL bypass_write: got wr=%b a=%0d d=%h rdy=%b pend=%b required 1/7/abcd/1/0",
               rd_write_o, rd_addr_o, rd_data_o, lu_ready_o, lu_pending_o);
    end else pass_cnt++;
    step();
    drive_idle();
    #2;
    total_cnt++;
    if ({lu_pending_o, rd_write_o} !== 2'b00) begin
      $display("FAIL bypass_after: got pend/wr=%b required 00", {lu_pending_o, rd_write_o});
    end else pass_cnt++;
    step();
  endtask

  task automatic test_buffer_drain();
    // cycle 0: pipeline busy, x3=1 pushed
    drive_pipe(5'd10, 32'd0);
    drive_lu(5'd3, 32'd1);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, stall_o, lu_ready_o} !== {1'b1, 5'd10, 1'b0, 1'b1}) begin
      $display("FAIL buf_c0: got wr=%b a=%0d st=%b rdy=%b required 1/10/0/1",
               rd_write_o, rd_addr_o, stall_o, lu_ready_o);
    end else pass_cnt++;
    step();
    // cycle 1: x4=2 pushed
    drive_pipe(5'd11, 32'd1);
    drive_lu(5'd4, 32'd2);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, lu_ready_o, lu_pending_o} !== {1'b1, 5'd11, 1'b1, 1'b1}) begin
      $display("FAIL buf_c1: got wr=%b a=%0d rdy=%b pend=%b required 1/11/1/1",
               rd_write_o, rd_addr_o, lu_ready_o, lu_pending_o);
    end else pass_cnt++;
    step();
    lu_valid_i = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      drive_pipe(5'(10 + c), 32'(c));
      #2;
      total_cnt++;
      if ({rd_write_o, rd_addr_o, rd_data_o, stall_o, lu_ready_o} !==
          {1'b1, 5'(10 + c), 32'(c), 1'b0, 1'b0}) begin
        $display("FAIL buf_wait_c%0d: got wr=%b a=%0d d=%h st=%b rdy=%b required 1/%0d/%h/0/0",
                 c, rd_write_o, rd_addr_o, rd_data_o, stall_o, lu_ready_o, 10 + c, c);
      end else pass_cnt++;
      step();
    end
    // cycle 5: starvation stall drains x3
    drive_pipe(5'd15, 32'd5);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o, stall_o} !== {1'b1, 5'd3, 32'd1, 1'b1}) begin
      $display("FAIL buf_stall1: got wr=%b a=%0d d=%h st=%b required 1/3/1/1",
               rd_write_o, rd_addr_o, rd_data_o, stall_o);
    end else pass_cnt++;
    step();
    // cycle 6: re-presented pipeline write
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o, stall_o, lu_ready_o} !==
        {1'b1, 5'd15, 32'd5, 1'b0, 1'b1}) begin
      $display("FAIL buf_represent: got wr=%b a=%0d d=%h st=%b rdy=%b required 1/15/5/0/1",
               rd_write_o, rd_addr_o, rd_data_o, stall_o, lu_ready_o);
    end else pass_cnt++;
    step();
    for (int c = 7; c <= 9; c++) begin
      drive_pipe(5'(10 + c), 32'(c));
      #2;
      total_cnt++;
      if ({rd_write_o, rd_addr_o, stall_o} !== {1'b1, 5'(10 + c), 1'b0}) begin
        $display("FAIL buf_wait2_c%0d: got wr=%b a=%0d st=%b required 1/%0d/0",
                 c, rd_write_o, rd_addr_o, stall_o, 10 + c);
      end else pass_cnt++;
      step();
    end
    // cycle 10: second stall drains x4
    drive_pipe(5'd20, 32'd10);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o, stall_o} !== {1'b1, 5'd4, 32'd2, 1'b1}) begin
      $display("FAIL buf_stall2: got wr=%b a=%0d d=%h st=%b required 1/4/2/1",
               rd_write_o, rd_addr_o, rd_data_o, stall_o);
    end else pass_cnt++;
    step();
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o, stall_o, lu_pending_o} !==
        {1'b1, 5'd20, 32'd10, 1'b0, 1'b0}) begin
      $display("FAIL buf_final: got wr=%b a=%0d d=%h st=%b pend=%b required 1/20/a/0/0",
               rd_write_o, rd_addr_o, rd_data_o, stall_o, lu_pending_o);
    end else pass_cnt++;
    step();
    drive_idle();
  endtask

  task automatic test_invalidation();
    drive_pipe(5'd1, 32'h1);
    drive_lu(5'd9, 32'h55);
    step();
    drive_idle();
    drive_pipe(5'd9, 32'h66);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o, lu_pending_o} !== {1'b1, 5'd9, 32'h66, 1'b1}) begin
      $display("FAIL inv_pipe: got wr=%b a=%0d d=%h pend=%b required 1/9/66/1",
               rd_write_o, rd_addr_o, rd_data_o, lu_pending_o);
    end else pass_cnt++;
    step();
    drive_idle();
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o} !== {1'b0, 5'd0, 32'h0}) begin
      $display("FAIL inv_killed_pop: got wr=%b a=%0d d=%h required 0/0/0",
               rd_write_o, rd_addr_o, rd_data_o);
    end else pass_cnt++;
    step();
    #2;
    total_cnt++;
    if ({rd_write_o, lu_pending_o} !== 2'b00) begin
      $display("FAIL inv_empty: got wr/pend=%b required 00", {rd_write_o, lu_pending_o});
    end else pass_cnt++;
    step();
  endtask

  task automatic test_rdy_low();
    drive_pipe(5'd2, 32'h2);
    drive_lu(5'd6, 32'h77);
    step();
    lu_valid_i = 1'b0;
    drive_pipe(5'd21, 32'h21);
    step();
    drive_pipe(5'd22, 32'h22);
    step();
    // freeze with starvation counter at 2
    rdy_in = 1'b0;
    drive_pipe(5'd23, 32'h23);
    drive_lu(5'd8, 32'h88);
    for (int c = 0; c < 3; c++) begin
      #2;
      total_cnt++;
      if ({rd_write_o, stall_o, lu_ready_o, lu_pending_o} !== 4'b0000) begin
        $display("FAIL rdy_low_c%0d: got wr/st/rdy/pend=%b required 0000",
                 c, {rd_write_o, stall_o, lu_ready_o, lu_pending_o});
      end else pass_cnt++;
      step();
    end
    rdy_in = 1'b1;
    lu_valid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_pipe(5'(24 + c), 32'(c));
      #2;
      total_cnt++;
      if ({rd_write_o, rd_addr_o, stall_o, lu_pending_o} !== {1'b1, 5'(24 + c), 1'b0, 1'b1}) begin
        $display("FAIL rdy_resume_c%0d: got wr=%b a=%0d st=%b pend=%b required 1/%0d/0/1",
                 c, rd_write_o, rd_addr_o, stall_o, lu_pending_o, 24 + c);
      end else pass_cnt++;
      step();
    end
    drive_pipe(5'd26, 32'h26);
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, rd_data_o, stall_o} !== {1'b1, 5'd6, 32'h77, 1'b1}) begin
      $display("FAIL rdy_stall: got wr=%b a=%0d d=%h st=%b required 1/6/77/1",
               rd_write_o, rd_addr_o, rd_data_o, stall_o);
    end else pass_cnt++;
    step();
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, stall_o, lu_pending_o} !== {1'b1, 5'd26, 1'b0, 1'b0}) begin
      $display("FAIL rdy_after: got wr=%b a=%0d st=%b pend=%b required 1/26/0/0",
               rd_write_o, rd_addr_o, stall_o, lu_pending_o);
    end else pass_cnt++;
    step();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_pipe(5'd1, 32'h1);
    drive_lu(5'd12, 32'h12);
    step();
    drive_lu(5'd13, 32'h13);
    step();
    drive_idle();
    #2;
    total_cnt++;
    if ({rd_write_o, rd_addr_o, lu_pending_o} !== {1'b1, 5'd12, 1'b1}) begin
      $display("FAIL rst_mid_before: got wr=%b a=%0d pend=%b required 1/12/1",
               rd_write_o, rd_addr_o, lu_pending_o);
    end else pass_cnt++;
    rst_in = 1'b1;
    #1;
    total_cnt++;
    if ({rd_write_o, lu_pending_o, lu_ready_o} !== 3'b000) begin
      $display("FAIL rst_mid_async: got wr/pend/rdy=%b required 000",
               {rd_write_o, lu_pending_o, lu_ready_o});
    end else pass_cnt++;
    step();
    rst_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      total_cnt++;
      if ({rd_write_o, lu_pending_o, lu_ready_o} !== 3'b001) begin
        $display("FAIL rst_mid_after_c%0d: got wr/pend/rdy=%b required 001",
                 c, {rd_write_o, lu_pending_o, lu_ready_o});
      end else pass_cnt++;
      step();
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_pipe_only();
    test_bypass();
    test_buffer_drain();
    test_invalidation();
    test_rdy_low();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
